serial_bus_arbiter: RTL and testbench

Central arbiter for the serial bus: grants bus ownership to one of `MASTER_NO` master out ports and tracks the owner's tenure. It forces a long-running owner off the bus through split so that waiting masters get service. It sits between every master's `bus_req`/`bus_util`/`bus_grant`/`split_en` pins and the shared address, data and burst lines.

---
 rtl/serial_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Serial bus arbiter: grants one master at a time, tracks tenure and splits long owners.
// Optional rotating priority is enabled by defining ARB_ROUND_ROBIN_EN (default: fixed priority).
module serial_bus_arbiter #(
    parameter int MASTER_NO     = 3,
    parameter int SPLIT_TENURE  = 32,
    parameter int GRANT_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MASTER_NO-1:0]         bus_req,
    input  logic [MASTER_NO-1:0]         bus_util,
    output logic [MASTER_NO-1:0]         bus_grant,
    output logic [MASTER_NO-1:0]         split_en,
    output logic [MASTER_NO-1:0]         split_pending,
    output logic [$clog2(MASTER_NO)-1:0] owner_id,
    output logic                         bus_busy
);

    localparam int ID_W = $clog2(MASTER_NO);
    localparam int TEN_W = (SPLIT_TENURE > 0) ? $clog2(SPLIT_TENURE + 1) : 1;
    localparam int TO_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(SPLIT_TENURE);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(GRANT_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GRANT      = 3'd1;
    localparam logic [2:0] S_BUSY       = 3'd2;
    localparam logic [2:0] S_SPLIT_WAIT = 3'd3;
    localparam logic [2:0] S_RELEASE    = 3'd4;

    logic [2:0]           state;
    logic [TEN_W-1:0]     tenure;
    logic [TO_W-1:0]      timeout;
    logic [MASTER_NO-1:0] req_pending;
    logic [MASTER_NO-1:0] cand;
    logic [MASTER_NO-1:0] owner_mask;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_valid;
    logic                 split_cond;
`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]      rr_ptr;
`endif

    // Previously split masters that are requesting again take precedence over fresh requests.
    always_comb begin
        req_pending = bus_req & split_pending;
        cand        = (req_pending != '0) ? req_pending : bus_req;
        pick_valid  = 1'b0;
        pick_id     = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < MASTER_NO; i++) begin
            if (!pick_valid && cand[i] && (i > int'(rr_ptr))) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < MASTER_NO; i++) begin
            if (!pick_valid && cand[i]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(i);
            end
        end
`else
        for (int i = 0; i < MASTER_NO; i++) begin
            if (!pick_valid && cand[i]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(i);
            end
        end
`endif
    end

    assign owner_mask = MASTER_NO'(1) << owner_id;
    assign split_cond = (SPLIT_TENURE != 0) && (tenure >= TEN_MAX) &&
                        ((bus_req & ~owner_mask) != '0);
    assign bus_busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus_grant     <= '0;
            split_en      <= '0;
            split_pending <= '0;
            owner_id      <= '0;
            tenure        <= '0;
            timeout       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr        <= ID_W'(MASTER_NO - 1);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner_id               <= pick_id;
                        bus_grant              <= MASTER_NO'(1) << pick_id;
                        split_pending[pick_id] <= 1'b0;
                        timeout                <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr                 <= pick_id;
`endif
                        state                  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (bus_util[owner_id]) begin
                        tenure <= '0;
                        state  <= S_BUSY;
                    end else if (timeout == TO_LAST) begin
                        bus_grant <= '0;
                        state     <= S_RELEASE;
                    end else begin
                        timeout <= timeout + 1'b1;
                    end
                end
                // A release seen in the same cycle as the split condition wins over the split.
                S_BUSY: begin
                    if (tenure < TEN_MAX) begin
                        tenure <= tenure + 1'b1;
                    end
                    if (!bus_util[owner_id]) begin
                        bus_grant <= '0;
                        state     <= S_RELEASE;
                    end else if (split_cond) begin
                        split_en <= owner_mask;
                        state    <= S_SPLIT_WAIT;
                    end
                end
                S_SPLIT_WAIT: begin
                    if (!bus_util[owner_id]) begin
                        split_en                <= '0;
                        bus_grant               <= '0;
                        split_pending[owner_id] <= 1'b1;
                        state                   <= S_RELEASE;
                    end
                end
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: grant/release timing, timeout, split, reset and policy order.
// Expected values are hand-computed; round-robin expectations follow ARB_ROUND_ROBIN_EN.
module tb_serial_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] bus_req;
    logic [2:0] bus_util;
    logic [2:0] bus_grant;
    logic [2:0] split_en;
    logic [2:0] split_pending;
    logic [1:0] owner_id;
    logic       bus_busy;

    int n_checks;
    int n_fail;

    serial_bus_arbiter #(
        .MASTER_NO     (3),
        .SPLIT_TENURE  (32),
        .GRANT_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_req       (bus_req),
        .bus_util      (bus_util),
        .bus_grant     (bus_grant),
        .split_en      (split_en),
        .split_pending (split_pending),
        .owner_id      (owner_id),
        .bus_busy      (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] util);
        bus_req  = req;
        bus_util = util;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] g, input logic [2:0] s,
                               input logic [2:0] p, input logic [1:0] o, input logic b);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {bus_grant, split_en, split_pending, owner_id, bus_busy};
        exp = {g, s, p, o, b};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: grant/split/pend/owner/busy observed %b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                   tag, obs[11:9], obs[8:6], obs[5:3], obs[2:1], obs[0],
                   exp[11:9], exp[8:6], exp[5:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        int         order[4];
        logic [2:0] g_exp;
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 2, 0};
`else
        order = '{0, 0, 0, 0};
`endif
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        applyStimulus(3'b000, 3'b000);
        step(2);
        checkOutput("reset", 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Basic grant, tenure and release with a 2-cycle dead bus
        applyStimulus(3'b110, 3'b000);
        step(1);
        checkOutput("t1_grant", 3'b010, 3'b000, 3'b000, 2'd1, 1'b1);
        step(1);
        checkOutput("t1_grant_hold", 3'b010, 3'b000, 3'b000, 2'd1, 1'b1);
        applyStimulus(3'b110, 3'b010);
        step(5);
        checkOutput("t1_busy", 3'b010, 3'b000, 3'b000, 2'd1, 1'b1);
        applyStimulus(3'b100, 3'b000);
        step(1);
        checkOutput("t1_release", 3'b000, 3'b000, 3'b000, 2'd1, 1'b1);
        step(1);
        checkOutput("t1_idle", 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);
        step(1);
        checkOutput("t1_next_grant", 3'b100, 3'b000, 3'b000, 2'd2, 1'b1);

        // Master 2 never raises util: grant held 8 cycles, then RELEASE
        applyStimulus(3'b000, 3'b000);
        step(7);
        checkOutput("to_hold", 3'b100, 3'b000, 3'b000, 2'd2, 1'b1);
        step(1);
        checkOutput("to_release", 3'b000, 3'b000, 3'b000, 2'd2, 1'b1);
        step(1);
        checkOutput("to_idle", 3'b000, 3'b000, 3'b000, 2'd2, 1'b0);

        // Long tenure by master 0 is split once master 1 requests
        applyStimulus(3'b001, 3'b000);
        step(1);
        checkOutput("sp_grant", 3'b001, 3'b000, 3'b000, 2'd0, 1'b1);
        applyStimulus(3'b001, 3'b001);
        step(6);
        applyStimulus(3'b011, 3'b001);
        step(27);
        checkOutput("sp_before", 3'b001, 3'b000, 3'b000, 2'd0, 1'b1);
        step(1);
        checkOutput("sp_split", 3'b001, 3'b001, 3'b000, 2'd0, 1'b1);
        step(3);
        checkOutput("sp_hold", 3'b001, 3'b001, 3'b000, 2'd0, 1'b1);
        applyStimulus(3'b010, 3'b000);
        step(1);
        checkOutput("sp_release", 3'b000, 3'b000, 3'b001, 2'd0, 1'b1);
        step(1);
        checkOutput("sp_idle", 3'b000, 3'b000, 3'b001, 2'd0, 1'b0);
        step(1);
        checkOutput("sp_grant_m1", 3'b010, 3'b000, 3'b001, 2'd1, 1'b1);
        applyStimulus(3'b010, 3'b010);
        step(1);
        applyStimulus(3'b101, 3'b000);
        step(1);
        checkOutput("sp_m1_release", 3'b000, 3'b000, 3'b001, 2'd1, 1'b1);
        step(2);
        checkOutput("sp_pending_wins", 3'b001, 3'b000, 3'b000, 2'd0, 1'b1);
        applyStimulus(3'b000, 3'b001);
        step(1);
        applyStimulus(3'b000, 3'b000);
        step(2);
        checkOutput("sp_clean", 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // Util falls exactly when the split condition first holds: plain release
        applyStimulus(3'b001, 3'b000);
        step(1);
        applyStimulus(3'b101, 3'b001);
        step(33);
        checkOutput("sim_before", 3'b001, 3'b000, 3'b000, 2'd0, 1'b1);
        applyStimulus(3'b100, 3'b000);
        step(1);
        checkOutput("sim_release", 3'b000, 3'b000, 3'b000, 2'd0, 1'b1);
        step(2);
        checkOutput("sim_next", 3'b100, 3'b000, 3'b000, 2'd2, 1'b1);
        applyStimulus(3'b000, 3'b100);
        step(1);
        applyStimulus(3'b000, 3'b000);
        step(2);

        // Reset asserted during SPLIT_WAIT
        applyStimulus(3'b001, 3'b000);
        step(1);
        applyStimulus(3'b011, 3'b001);
        step(34);
        checkOutput("rs_split", 3'b001, 3'b001, 3'b000, 2'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rs_async", 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        applyStimulus(3'b110, 3'b000);
        step(1);
        rst_n = 1'b1;
        step(1);
        checkOutput("rs_first", 3'b010, 3'b000, 3'b000, 2'd1, 1'b1);
        applyStimulus(3'b000, 3'b010);
        step(1);
        applyStimulus(3'b000, 3'b000);
        step(2);
        checkOutput("rs_clean", 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);

        // Policy order with all masters requesting permanently
        rst_n = 1'b0;
        step(1);
        checkOutput("rr_reset", 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g_exp = 3'b001 << order[i];
            applyStimulus(3'b111, 3'b000);
            step(1);
            checkOutput($sformatf("po_grant%0d", i), g_exp, 3'b000, 3'b000, 2'(order[i]), 1'b1);
            applyStimulus(3'b111, g_exp);
            step(3);
            applyStimulus(3'b111, 3'b000);
            step(1);
            checkOutput($sformatf("po_release%0d", i), 3'b000, 3'b000, 3'b000, 2'(order[i]), 1'b1);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
